// File: rtl/mult_pkg.sv
// Shared definitions for the serial multiplier controller: state encoding
// and default operand width.
package mult_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/right_shifter.sv
// Upstream free-running right shifter: loads the multiplier on load, otherwise
// shifts right by one every cycle so out[0] presents the bits LSB first.
module right_shifter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] out
);

  always_ff @(posedge clock) begin
    if (rst)
      out <= '0;
    else if (load)
      out <= a;
    else
      out <= out >> 1;
  end

endmodule

// File: rtl/serial_mult_ctrl.sv
// Shift-and-add serial multiplier controller: strobes the upstream shifter,
// accumulates one multiplier bit per RUN cycle and pulses done with the product.
module serial_mult_ctrl
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic               clock,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   mcand,
  input  logic               lsb_in,
  output logic               shf_load,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   mcand_reg;
  logic [2*WIDTH-1:0] acc, acc_next, addend;
  logic               last_bit;

  // Zero-extend before shifting so the partial product never loses high bits.
  always_comb begin
    addend   = {{WIDTH{1'b0}}, mcand_reg} << cnt;
    last_bit = (cnt == CNT_W'(WIDTH - 1));
    acc_next = acc;
    if (state == RUN && lsb_in)
      acc_next = acc + addend;
  end

  always_ff @(posedge clock) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    shf_load   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start)
          state_next = LOAD;
      end
      LOAD: begin
        shf_load   = 1'b1;
        busy       = 1'b1;
        state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit)
          state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Product is captured on the final RUN edge so it is valid throughout DONE
  // and then held while idle.
  always_ff @(posedge clock) begin
    if (rst) begin
      cnt       <= '0;
      acc       <= '0;
      mcand_reg <= '0;
      product   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand_reg <= mcand;
            acc       <= '0;
            cnt       <= '0;
          end
        end
        RUN: begin
          acc <= acc_next;
          cnt <= cnt + CNT_W'(1);
          if (last_bit)
            product <= acc_next;
        end
        default: ;
      endcase
    end
  end

endmodule
